// File: rtl/param_updown_counter.sv
// param_updown_counter
// Registered up/down counter/accumulator with a programmable step, parallel
// load, wrap-or-saturate bounds handling and carry/borrow event reporting.
// q, zero and tc are all registered so downstream logic sees no
// combinational path from the inputs.
module param_updown_counter #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             borrow;
  logic             event_hit;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             ovf_next;

  // Raw arithmetic; the extra sum bit is the carry out. Landing exactly on
  // all-ones (up) or on zero (down) is deliberately not an event.
  always_comb begin
    sum    = {1'b0, q} + {1'b0, step};
    carry  = sum[WIDTH];
    diff   = q - step;
    borrow = (step > q);
  end

  // Bound handling: saturate clamps to the crossed bound, wrap keeps the
  // modulo result. A counter parked at a bound still reports each crossing.
  always_comb begin
    if (dir) begin
      event_hit  = carry;
      count_next = (carry && sat) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end else begin
      event_hit  = borrow;
      count_next = (borrow && sat) ? {WIDTH{1'b0}} : diff;
    end
  end

  // Next-state selection with load over enable over hold; a set of the
  // sticky flag beats a simultaneous clear so no event is ever lost.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      q_next  = count_next;
      tc_next = event_hit;
    end
    if (tc_next) begin
      ovf_next = 1'b1;
    end else if (clr_flag) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf;
    end
  end

  // State registers; zero is registered from the next value so it lines up
  // with q on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RESET_VAL;
      zero <= (RESET_VAL == {WIDTH{1'b0}});
      tc   <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_next;
      zero <= (q_next == {WIDTH{1'b0}});
      tc   <= tc_next;
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed and randomized checks for param_updown_counter: a 16-bit instance
// for the directed scenarios and a 4-bit instance (RESET_VAL=3) checked
// against a small behavioural model.
module tb_param_updown_counter;

  logic clk;
  int   n_checks;
  int   n_fail;

  // 16-bit instance signals
  logic        rst16, a_load, a_en, a_dir, a_sat, a_clr;
  logic [15:0] a_load_val, a_step, a_q;
  logic        a_zero, a_tc, a_ovf;

  // 4-bit instance signals
  logic        rst4, b_load, b_en, b_dir, b_sat, b_clr;
  logic [3:0]  b_load_val, b_step, b_q;
  logic        b_zero, b_tc, b_ovf;

  // behavioural model state for the 4-bit instance
  int m_q, m_tc, m_ovf;

  param_updown_counter #(.WIDTH(16), .RESET_VAL(16'h0000)) dut16 (
    .clk(clk), .rst(rst16), .load(a_load), .load_val(a_load_val), .en(a_en),
    .dir(a_dir), .step(a_step), .sat(a_sat), .clr_flag(a_clr),
    .q(a_q), .zero(a_zero), .tc(a_tc), .ovf(a_ovf)
  );

  param_updown_counter #(.WIDTH(4), .RESET_VAL(4'h3)) dut4 (
    .clk(clk), .rst(rst4), .load(b_load), .load_val(b_load_val), .en(b_en),
    .dir(b_dir), .step(b_step), .sat(b_sat), .clr_flag(b_clr),
    .q(b_q), .zero(b_zero), .tc(b_tc), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_load = 0; a_en = 0; a_dir = 0; a_sat = 0; a_clr = 0;
    a_load_val = '0; a_step = '0;
  endtask

  task automatic test_reset();
    // reset asserted from time zero
    #1;
    n_checks++;
    if ({a_q, a_zero, a_tc, a_ovf} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial got q=%h z=%b tc=%b ovf=%b want q=0000 z=1 tc=0 ovf=0", a_q, a_zero, a_tc, a_ovf);
    end
    tick();
    #2 rst16 = 0;
    // load all-ones then count up through the carry so ovf becomes set
    a_load = 1; a_load_val = 16'hFFFF;
    tick();
    a_load = 0; a_en = 1; a_dir = 1; a_step = 16'h0001; a_sat = 0;
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc, a_ovf} !== {16'h0000, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_precount_wrap got q=%h z=%b tc=%b ovf=%b want q=0000 z=1 tc=1 ovf=1", a_q, a_zero, a_tc, a_ovf);
    end
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc, a_ovf} !== {16'h0001, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_precount_step got q=%h z=%b tc=%b ovf=%b want q=0001 z=0 tc=0 ovf=1", a_q, a_zero, a_tc, a_ovf);
    end
    // mid-cycle async reset with en still active
    #2 rst16 = 1;
    #1;
    n_checks++;
    if ({a_q, a_zero, a_tc, a_ovf} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async_immediate got q=%h z=%b tc=%b ovf=%b want q=0000 z=1 tc=0 ovf=0", a_q, a_zero, a_tc, a_ovf);
    end
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc, a_ovf} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held got q=%h z=%b tc=%b ovf=%b want q=0000 z=1 tc=0 ovf=0", a_q, a_zero, a_tc, a_ovf);
    end
    #2 rst16 = 0;
    a_idle();
    tick();
  endtask

  task automatic test_decrement_wrap();
    a_load = 1; a_load_val = 16'h0001;
    tick();
    a_load = 0; a_en = 1; a_dir = 0; a_step = 16'h0001; a_sat = 0;
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc, a_ovf} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL dec_to_zero got q=%h z=%b tc=%b ovf=%b want q=0000 z=1 tc=0 ovf=0", a_q, a_zero, a_tc, a_ovf);
    end
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc, a_ovf} !== {16'hFFFF, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL dec_wrap got q=%h z=%b tc=%b ovf=%b want q=FFFF z=0 tc=1 ovf=1", a_q, a_zero, a_tc, a_ovf);
    end
    a_en = 0;
    tick();
    n_checks++;
    if ({a_q, a_tc, a_ovf} !== {16'hFFFF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL dec_hold_sticky got q=%h tc=%b ovf=%b want q=FFFF tc=0 ovf=1", a_q, a_tc, a_ovf);
    end
    a_clr = 1;
    tick();
    a_clr = 0;
    n_checks++;
    if ({a_q, a_tc, a_ovf} !== {16'hFFFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL dec_clr got q=%h tc=%b ovf=%b want q=FFFF tc=0 ovf=0", a_q, a_tc, a_ovf);
    end
  endtask

  task automatic test_saturate_up();
    a_load = 1; a_load_val = 16'hFFF0;
    tick();
    a_load = 0; a_en = 1; a_dir = 1; a_step = 16'h0020; a_sat = 1;
    tick();
    n_checks++;
    if ({a_q, a_tc, a_ovf} !== {16'hFFFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_up_first got q=%h tc=%b ovf=%b want q=FFFF tc=1 ovf=1", a_q, a_tc, a_ovf);
    end
    tick();
    n_checks++;
    if ({a_q, a_tc, a_ovf} !== {16'hFFFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_up_again got q=%h tc=%b ovf=%b want q=FFFF tc=1 ovf=1", a_q, a_tc, a_ovf);
    end
    // simultaneous event and clear: set wins
    a_clr = 1;
    tick();
    n_checks++;
    if ({a_q, a_tc, a_ovf} !== {16'hFFFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_set_beats_clr got q=%h tc=%b ovf=%b want q=FFFF tc=1 ovf=1", a_q, a_tc, a_ovf);
    end
    a_en = 0;
    tick();
    a_clr = 0;
    n_checks++;
    if ({a_q, a_tc, a_ovf} !== {16'hFFFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_clr_alone got q=%h tc=%b ovf=%b want q=FFFF tc=0 ovf=0", a_q, a_tc, a_ovf);
    end
  endtask

  task automatic test_priority_hold();
    a_load = 1; a_load_val = 16'h1234; a_en = 1; a_dir = 1; a_step = 16'h0005; a_sat = 0;
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc} !== {16'h1234, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_load_wins got q=%h z=%b tc=%b want q=1234 z=0 tc=0", a_q, a_zero, a_tc);
    end
    a_load = 0; a_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({a_q, a_tc} !== {16'h1234, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got q=%h tc=%b want q=1234 tc=0", i, a_q, a_tc);
      end
    end
    // enabled count from the loaded value
    a_en = 1;
    tick();
    n_checks++;
    if ({a_q, a_tc} !== {16'h1239, 1'b0}) begin
      n_fail++;
      $display("FAIL count_after_load got q=%h tc=%b want q=1239 tc=0", a_q, a_tc);
    end
    a_en = 0;
  endtask

  task automatic test_exact_bound();
    a_load = 1; a_load_val = 16'h0005;
    tick();
    a_load = 0; a_en = 1; a_dir = 0; a_step = 16'h0005; a_sat = 1;
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL exact_down_land got q=%h z=%b tc=%b want q=0000 z=1 tc=0", a_q, a_zero, a_tc);
    end
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_down_cross got q=%h z=%b tc=%b want q=0000 z=1 tc=1", a_q, a_zero, a_tc);
    end
    a_step = 16'h0000;
    tick();
    n_checks++;
    if ({a_q, a_zero, a_tc} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL step_zero got q=%h z=%b tc=%b want q=0000 z=1 tc=0", a_q, a_zero, a_tc);
    end
    // up to exactly all-ones in wrap mode is not a carry
    a_en = 0; a_load = 1; a_load_val = 16'hFFF0;
    tick();
    a_load = 0; a_en = 1; a_dir = 1; a_step = 16'h000F; a_sat = 0;
    tick();
    n_checks++;
    if ({a_q, a_tc} !== {16'hFFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL exact_up_land got q=%h tc=%b want q=FFFF tc=0", a_q, a_tc);
    end
    // wrap-mode up crossing
    a_step = 16'h0003;
    tick();
    n_checks++;
    if ({a_q, a_tc} !== {16'h0002, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_up_cross got q=%h tc=%b want q=0002 tc=1", a_q, a_tc);
    end
    a_idle();
  endtask

  task automatic test_param_sweep();
    int nq, ntc, novf, s;
    n_checks++;
    if ({b_q, b_zero, b_tc, b_ovf} !== {4'h3, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL w4_reset_val got q=%h z=%b tc=%b ovf=%b want q=3 z=0 tc=0 ovf=0", b_q, b_zero, b_tc, b_ovf);
    end
    b_en = 1; b_dir = 1; b_step = 4'd7; b_sat = 0;
    tick();
    n_checks++;
    if ({b_q, b_tc} !== {4'hA, 1'b0}) begin
      n_fail++;
      $display("FAIL w4_up_first got q=%h tc=%b want q=A tc=0", b_q, b_tc);
    end
    tick();
    n_checks++;
    if ({b_q, b_tc, b_ovf} !== {4'h1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL w4_up_wrap got q=%h tc=%b ovf=%b want q=1 tc=1 ovf=1", b_q, b_tc, b_ovf);
    end
    m_q = 1; m_tc = 1; m_ovf = 1;
    for (int i = 0; i < 1000; i++) begin
      b_load     = ($urandom_range(0, 7) == 0);
      b_load_val = 4'($urandom_range(0, 15));
      b_en       = ($urandom_range(0, 3) != 0);
      b_dir      = 1'($urandom_range(0, 1));
      b_step     = 4'($urandom_range(0, 15));
      b_sat      = 1'($urandom_range(0, 1));
      b_clr      = ($urandom_range(0, 7) == 0);
      nq = m_q; ntc = 0;
      if (b_load) begin
        nq = int'(b_load_val);
      end else if (b_en) begin
        if (b_dir) begin
          s = m_q + int'(b_step);
          ntc = (s > 15) ? 1 : 0;
          nq = (s > 15) ? (b_sat ? 15 : s - 16) : s;
        end else begin
          ntc = (int'(b_step) > m_q) ? 1 : 0;
          nq = ntc ? (b_sat ? 0 : m_q - int'(b_step) + 16) : m_q - int'(b_step);
        end
      end
      novf = ntc ? 1 : (b_clr ? 0 : m_ovf);
      m_q = nq; m_tc = ntc; m_ovf = novf;
      tick();
      n_checks++;
      if (b_q !== 4'(m_q) || b_zero !== (m_q == 0) || b_tc !== 1'(m_tc) || b_ovf !== 1'(m_ovf)) begin
        n_fail++;
        $display("FAIL w4_model cyc=%0d got q=%h z=%b tc=%b ovf=%b want q=%h z=%b tc=%b ovf=%b",
                 i, b_q, b_zero, b_tc, b_ovf, 4'(m_q), (m_q == 0), 1'(m_tc), 1'(m_ovf));
      end
      if ($urandom_range(0, 39) == 0) begin
        #1 rst4 = 1;
        #1;
        m_q = 3; m_tc = 0; m_ovf = 0;
        n_checks++;
        if ({b_q, b_zero, b_tc, b_ovf} !== {4'h3, 1'b0, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL w4_async_rst cyc=%0d got q=%h z=%b tc=%b ovf=%b want q=3 z=0 tc=0 ovf=0", i, b_q, b_zero, b_tc, b_ovf);
        end
        #1 rst4 = 0;
      end
    end
    b_load = 0; b_en = 0; b_clr = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst16 = 1; rst4 = 1;
    a_idle();
    b_load = 0; b_en = 0; b_dir = 0; b_sat = 0; b_clr = 0;
    b_load_val = '0; b_step = '0;
    test_reset();
    #2 rst4 = 0;
    test_decrement_wrap();
    test_saturate_up();
    test_priority_hold();
    test_exact_bound();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
